ram_dp_clr: RTL and testbench
=============================

RAM_DP_CLR -- requirements
Module: ram_dp_clr

Interface
REQ-001 Parameter DATA_W, default 4, data word width in bits (legal range 1..64).
REQ-002 Parameter ADDR_W, default 7, address width in bits; depth DEPTH = 2**ADDR_W words.
REQ-003 Parameter RD_MODE, default 0, same-address collision mode: 0 = read-first (old data), 1 = write-first (new data).
REQ-004 Ports:
- clk  input  1  single clock for all state; all sequential elements update on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- wr_en  input  1  write request, sampled at the clk rising edge.
- wr_addr  input  ADDR_W  write address.
- wr_data  input  DATA_W  write data.
- rd_en  input  1  read request, sampled at the clk rising edge.
- rd_addr  input  ADDR_W  read address.
- rd_data  output  DATA_W  registered read data.
- rd_valid  output  1  one-cycle pulse qualifying rd_data.
- clr  input  1  single-cycle request to zero the whole array.
- init_busy  output  1  high while the clear sweep runs; all port accesses are dropped.

Function
REQ-005 The block SHALL have two states: INIT (clear sweep) and RUN (normal access).
REQ-006 In INIT, the block SHALL write 0 to address sweep_cnt on each cycle, then increment sweep_cnt by 1.
REQ-007 Sweep progression: when sweep_cnt = DEPTH-1 and that word is written, the next state SHALL be RUN and sweep_cnt SHALL return to 0; a full sweep takes exactly DEPTH cycles.
REQ-008 init_busy SHALL be 1 in INIT and 0 in RUN.
REQ-009 In INIT, wr_en and rd_en SHALL be ignored: no array write, rd_valid = 0, rd_data holds its value.
REQ-010 In INIT, clr SHALL be ignored; the sweep continues without restarting.
REQ-011 In RUN, clr = 1 SHALL move the block to INIT on the next cycle with sweep_cnt = 0.
REQ-012 clr SHALL take priority over any wr_en or rd_en in the same cycle; both are dropped and rd_valid stays 0 in the following cycle.
REQ-013 In RUN, wr_en = 1 SHALL write wr_data to wr_addr at that clock edge.
REQ-014 In RUN, rd_en = 1 SHALL update rd_data at that same edge with the word at rd_addr, and SHALL drive rd_valid = 1 for exactly one cycle; read latency is 1 cycle.
REQ-015 When rd_en = 0, or the block is in INIT, rd_valid SHALL be 0 and rd_data SHALL hold its last value.
REQ-016 Collision (RUN, wr_en = rd_en = 1, wr_addr = rd_addr):
- RD_MODE = 0: rd_data SHALL return the pre-write contents.
- RD_MODE = 1: rd_data SHALL return wr_data.
- In either mode, the array SHALL hold wr_data afterwards.
REQ-017 Reads and writes to different addresses in the same cycle SHALL both complete independently.
REQ-018 Addresses SHALL wrap naturally at ADDR_W bits; every address value is legal and no range check is performed.
REQ-019 sweep_cnt SHALL be ADDR_W bits wide, and the terminal-count compare SHALL be against DEPTH-1.

Reset
REQ-020 Asserting rst (low) SHALL immediately, without waiting for clk, set:
- state = INIT, sweep_cnt = 0, rd_data = 0, rd_valid = 0, init_busy = 1.
REQ-021 The memory array SHALL NOT be asynchronously reset; it is zeroed only by the sweep, which starts at the first rising clk edge after rst deasserts.
REQ-022 rst asserted mid-sweep or mid-access SHALL abort the operation; after release, a complete DEPTH-cycle sweep SHALL run again from address 0.

Verification
REQ-023 Release rst, hold rd_en/wr_en = 0 -> init_busy = 1 for exactly 128 cycles, then 0; read of any address then returns 0 with rd_valid pulse.
REQ-024 RUN: write 0xA to addr 5, next cycle rd_en at addr 5 -> rd_data = 0xA and rd_valid = 1 one cycle after the read request; rd_valid = 0 the cycle after.
REQ-025 RUN, addr 9 holds 0x3: wr 0xC and rd addr 9 in the same cycle -> RD_MODE = 0 returns 0x3; RD_MODE = 1 returns 0xC; a later read returns 0xC in both modes.
REQ-026 RUN: fill addr 0..127 with nonzero data, pulse clr together with wr_en (addr 1, 0x7) -> write dropped, init_busy high for 128 cycles, all addresses then read 0.
REQ-027 INIT at sweep_cnt = 60: pulse clr, wr_en, rd_en -> sweep completes at the original cycle count, rd_valid stays 0, target word reads 0 afterwards.
REQ-028 Assert rst mid-sweep and also during a RUN read -> outputs go to reset values immediately; full 128-cycle sweep after release; parameter variant DATA_W = 16, ADDR_W = 3 passes REQ-023 with 8-cycle sweep.

Source files
------------

// File: rtl/ram_dp_clr.sv
// Simple dual-port RAM (one write port, one registered read port) with a
// self-clearing sweep that zeroes every word after reset or on a clr request.
module ram_dp_clr #(
  parameter int DATA_W  = 4,
  parameter int ADDR_W  = 7,
  parameter int RD_MODE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              clr,
  output logic              init_busy,
  output logic              o_dbg_state
);

  localparam int                DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADR = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_sweep_cnt;
  logic [ADDR_W-1:0] w_sweep_nxt;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid;

  logic              w_run;
  logic              w_wr_fire;
  logic              w_rd_fire;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_data;
  logic [DATA_W-1:0] w_rd_word;

  // Handshake: rd_en is accepted unconditionally in RUN without clr (no ready);
  // rd_valid pulses for exactly one cycle, one clock after the accepted rd_en.
  assign w_run     = (r_state == ST_RUN);
  assign w_wr_fire = w_run && !clr && wr_en;
  assign w_rd_fire = w_run && !clr && rd_en;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_INIT;
      r_sweep_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_sweep_cnt <= w_sweep_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sweep_nxt = r_sweep_cnt;
    case (r_state)
      ST_INIT: begin
        if (r_sweep_cnt == LAST_ADR) begin
          w_state_nxt = ST_RUN;
          w_sweep_nxt = '0;
        end else begin
          w_sweep_nxt = r_sweep_cnt + 1'b1;
        end
      end
      ST_RUN: begin
        if (clr) begin
          w_state_nxt = ST_INIT;
          w_sweep_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = ST_INIT;
        w_sweep_nxt = '0;
      end
    endcase
  end

  // The sweep owns the write port while in INIT; user writes only in RUN.
  assign w_mem_we   = !w_run || w_wr_fire;
  assign w_mem_addr = w_run ? wr_addr : r_sweep_cnt;
  assign w_mem_data = w_run ? wr_data : '0;

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_data;
    end
  end

  assign w_rd_word = ((RD_MODE == 1) && w_wr_fire && (wr_addr == rd_addr))
                   ? wr_data : r_mem[rd_addr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_fire;
      if (w_rd_fire) begin
        r_rd_data <= w_rd_word;
      end
    end
  end

  assign rd_data     = r_rd_data;
  assign rd_valid    = r_rd_valid;
  assign init_busy   = !w_run;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ram_dp_clr.sv
// Bench for ram_dp_clr: two default-size instances (read-first and write-first)
// share stimulus; a third small instance (16-bit x 8) checks the parameter variant.
module tb_ram_dp_clr;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       wr_en = 1'b0, rd_en = 1'b0, clr = 1'b0;
  logic [6:0] wr_addr = '0, rd_addr = '0;
  logic [3:0] wr_data = '0;
  logic [3:0] rd_data0, rd_data1;
  logic       rd_valid0, rd_valid1, busy0, busy1, dbg0, dbg1;

  logic        wr_en2 = 1'b0, rd_en2 = 1'b0, clr2 = 1'b0;
  logic [2:0]  wr_addr2 = '0, rd_addr2 = '0;
  logic [15:0] wr_data2 = '0;
  logic [15:0] rd_data2;
  logic        rd_valid2, busy2, dbg2;

  ram_dp_clr #(.DATA_W(4), .ADDR_W(7), .RD_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data0), .rd_valid(rd_valid0),
    .clr(clr), .init_busy(busy0), .o_dbg_state(dbg0));

  ram_dp_clr #(.DATA_W(4), .ADDR_W(7), .RD_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1), .rd_valid(rd_valid1),
    .clr(clr), .init_busy(busy1), .o_dbg_state(dbg1));

  ram_dp_clr #(.DATA_W(16), .ADDR_W(3), .RD_MODE(0)) dut2 (
    .clk(clk), .rst(rst), .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2),
    .rd_en(rd_en2), .rd_addr(rd_addr2), .rd_data(rd_data2), .rd_valid(rd_valid2),
    .clr(clr2), .init_busy(busy2), .o_dbg_state(dbg2));

  // ---------------- scoreboard / model ----------------
  int         n_cmp = 0;
  int         n_err = 0;
  logic [3:0] exp_q0[$];
  logic [3:0] exp_q1[$];
  logic [3:0] m_mem[128];
  logic [3:0] m_last0, m_last1;
  bit         m_run;
  int         m_cnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called at a negedge: drives one cycle, updates the model, checks after the edge.
  task automatic step(input bit we, input logic [6:0] wa, input logic [3:0] wd,
                      input bit re, input logic [6:0] ra, input bit c,
                      input logic [3:0] e0, input logic [3:0] e1);
    logic [3:0] ev;
    wr_en = we; wr_addr = wa; wr_data = wd; rd_en = re; rd_addr = ra; clr = c;
    if (!m_run) begin
      m_mem[m_cnt] = '0;
      if (m_cnt == 127) begin m_run = 1'b1; m_cnt = 0; end
      else m_cnt++;
    end else if (c) begin
      m_run = 1'b0; m_cnt = 0;
    end else begin
      if (re) begin exp_q0.push_back(e0); exp_q1.push_back(e1); end
      if (we) m_mem[wa] = wd;
    end
    @(posedge clk); #1;
    check("busy0", busy0, !m_run);
    check("busy1", busy1, !m_run);
    if (exp_q0.size() > 0) begin
      ev = exp_q0.pop_front();
      check("valid0", rd_valid0, 1'b1);
      check("data0", rd_data0, ev);
      m_last0 = ev;
    end else begin
      check("valid0_idle", rd_valid0, 1'b0);
      check("data0_hold", rd_data0, m_last0);
    end
    if (exp_q1.size() > 0) begin
      ev = exp_q1.pop_front();
      check("valid1", rd_valid1, 1'b1);
      check("data1", rd_data1, ev);
      m_last1 = ev;
    end else begin
      check("valid1_idle", rd_valid1, 1'b0);
      check("data1_hold", rd_data1, m_last1);
    end
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0; clr = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, 7'd0, 4'd0, 1'b0, 7'd0, 1'b0, 4'd0, 4'd0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #2;
    check("rst_busy0", busy0, 1'b1);
    check("rst_valid0", rd_valid0, 1'b0);
    check("rst_data0", rd_data0, 4'd0);
    check("rst_data1", rd_data1, 4'd0);
    m_run = 1'b0; m_cnt = 0; m_last0 = '0; m_last1 = '0;
    exp_q0.delete(); exp_q1.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
  endtask

  // Counts clock edges until init_busy drops; 'already' covers sweep cycles done earlier.
  task automatic wait_sweep(input int already, input string name);
    int n;
    n = already;
    for (int k = 0; k < 300; k++) begin
      idle();
      n++;
      if (!busy0) break;
    end
    check(name, n, 128);
  endtask

  typedef struct {
    bit         we;
    logic [6:0] wa;
    logic [3:0] wd;
    bit         re;
    logic [6:0] ra;
    logic [3:0] e0;
    logic [3:0] e1;
  } vec_t;

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{1'b1, 7'd5,   4'hA, 1'b0, 7'd0,   4'h0, 4'h0};
    tbl[1]  = '{1'b0, 7'd0,   4'h0, 1'b1, 7'd5,   4'hA, 4'hA};
    tbl[2]  = '{1'b0, 7'd0,   4'h0, 1'b0, 7'd0,   4'h0, 4'h0};
    tbl[3]  = '{1'b1, 7'd9,   4'h3, 1'b0, 7'd0,   4'h0, 4'h0};
    tbl[4]  = '{1'b1, 7'd9,   4'hC, 1'b1, 7'd9,   4'h3, 4'hC};
    tbl[5]  = '{1'b0, 7'd0,   4'h0, 1'b1, 7'd9,   4'hC, 4'hC};
    tbl[6]  = '{1'b0, 7'd0,   4'h0, 1'b1, 7'd0,   4'h0, 4'h0};
    tbl[7]  = '{1'b1, 7'd127, 4'hF, 1'b1, 7'd5,   4'hA, 4'hA};
    tbl[8]  = '{1'b0, 7'd0,   4'h0, 1'b1, 7'd127, 4'hF, 4'hF};
    tbl[9]  = '{1'b1, 7'd0,   4'h1, 1'b1, 7'd127, 4'hF, 4'hF};
    tbl[10] = '{1'b0, 7'd0,   4'h0, 1'b1, 7'd0,   4'h1, 4'h1};
    tbl[11] = '{1'b0, 7'd0,   4'h0, 1'b1, 7'd100, 4'h0, 4'h0};

    for (int i = 0; i < 128; i++) m_mem[i] = 4'hX;

    // Reset, first sweep, then every word reads 0
    do_reset();
    wait_sweep(0, "sweep_after_reset");
    for (int i = 0; i < 128; i += 17) step(1'b0, 7'd0, 4'd0, 1'b1, 7'(i), 1'b0, 4'd0, 4'd0);

    // Directed vectors
    for (int i = 0; i < 12; i++)
      step(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].re, tbl[i].ra, 1'b0, tbl[i].e0, tbl[i].e1);

    // Random traffic with collisions forced onto a small address window
    for (int i = 0; i < 300; i++) begin
      bit         we, re;
      logic [6:0] wa, ra;
      logic [3:0] wd;
      we = bit'($urandom_range(1));
      re = bit'($urandom_range(1));
      wa = 7'($urandom_range(15));
      ra = 7'($urandom_range(15));
      wd = 4'($urandom_range(15));
      step(we, wa, wd, re, ra, 1'b0, m_mem[ra], (we && wa == ra) ? wd : m_mem[ra]);
    end

    // Fill all words nonzero, then clr with a colliding write/read
    for (int i = 0; i < 128; i++) step(1'b1, 7'(i), 4'((i % 15) + 1), 1'b0, 7'd0, 1'b0, 4'd0, 4'd0);
    step(1'b1, 7'd1, 4'h7, 1'b1, 7'd1, 1'b1, 4'd0, 4'd0);
    wait_sweep(0, "sweep_after_clr");
    for (int i = 0; i < 128; i++) step(1'b0, 7'd0, 4'd0, 1'b1, 7'(i), 1'b0, 4'd0, 4'd0);

    // clr/wr/rd during INIT at sweep_cnt = 60 are ignored
    step(1'b1, 7'd10, 4'h9, 1'b0, 7'd0, 1'b0, 4'd0, 4'd0);
    step(1'b0, 7'd0, 4'd0, 1'b0, 7'd0, 1'b1, 4'd0, 4'd0);
    for (int i = 0; i < 60; i++) idle();
    step(1'b1, 7'd10, 4'h9, 1'b1, 7'd10, 1'b1, 4'd0, 4'd0);
    wait_sweep(61, "sweep_clr_in_init");
    step(1'b0, 7'd0, 4'd0, 1'b1, 7'd10, 1'b0, 4'd0, 4'd0);

    // Reset during a RUN read, then during a sweep
    step(1'b1, 7'd5, 4'hA, 1'b0, 7'd0, 1'b0, 4'd0, 4'd0);
    step(1'b0, 7'd0, 4'd0, 1'b1, 7'd5, 1'b0, 4'hA, 4'hA);
    do_reset();
    wait_sweep(0, "sweep_rst_in_run");
    step(1'b1, 7'd5, 4'hA, 1'b0, 7'd0, 1'b0, 4'd0, 4'd0);
    step(1'b0, 7'd0, 4'd0, 1'b1, 7'd5, 1'b0, 4'hA, 4'hA);
    step(1'b0, 7'd0, 4'd0, 1'b0, 7'd0, 1'b1, 4'd0, 4'd0);
    for (int i = 0; i < 30; i++) idle();
    do_reset();
    wait_sweep(0, "sweep_rst_in_init");
    step(1'b0, 7'd0, 4'd0, 1'b1, 7'd5, 1'b0, 4'd0, 4'd0);

    // Small variant: 8-cycle sweep, zeros, then a 16-bit write/read
    do_reset();
    begin
      int n2;
      n2 = 0;
      for (int k = 0; k < 50; k++) begin
        @(posedge clk); #1;
        n2++;
        if (!busy2) break;
      end
      check("sweep_len2", n2, 8);
      @(negedge clk);
    end
    for (int i = 0; i < 8; i++) begin
      rd_en2 = 1'b1; rd_addr2 = 3'(i);
      @(posedge clk); #1;
      check("valid2", rd_valid2, 1'b1);
      check("data2_zero", rd_data2, 16'h0000);
      @(negedge clk);
    end
    rd_en2 = 1'b0; wr_en2 = 1'b1; wr_addr2 = 3'd6; wr_data2 = 16'hBEEF;
    @(posedge clk); #1;
    check("valid2_wr_only", rd_valid2, 1'b0);
    @(negedge clk);
    wr_en2 = 1'b0; rd_en2 = 1'b1; rd_addr2 = 3'd6;
    @(posedge clk); #1;
    check("valid2_rd", rd_valid2, 1'b1);
    check("data2_beef", rd_data2, 16'hBEEF);
    @(negedge clk);
    rd_en2 = 1'b0;
    @(posedge clk); #1;
    check("valid2_drop", rd_valid2, 1'b0);
    check("data2_hold", rd_data2, 16'hBEEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
